// File: rtl/track_scheduler.sv
// Latches per-track play requests, grants one by priority and drives the shared beat counter.
// Grant 1 cycle after the pending bit sets; done/aborted are registered into the first IDLE cycle.
module track_scheduler #(
  parameter int N_TRACKS = 9,
  parameter int BEAT_W   = 12,
  parameter int DIV_W    = 25,
  parameter int DEF_LEN  = 112,
  parameter int DEF_DIV  = 2097152
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRACKS-1:0] req,
  input  logic                stop,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_track,
  input  logic [BEAT_W-1:0]   cfg_len,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [1:0]          cfg_prio,
  input  logic                cfg_loop,
  output logic                active,
  output logic [3:0]          track_id,
  output logic [BEAT_W-1:0]   ibeat,
  output logic                beat_tick,
  output logic                done,
  output logic                aborted
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  state_t state, stateNext;

  localparam logic [4:0] NUM_TRACKS = 5'(N_TRACKS);

  logic [BEAT_W-1:0]   lenTab  [N_TRACKS];
  logic [DIV_W-1:0]    divTab  [N_TRACKS];
  logic [1:0]          prioTab [N_TRACKS];
  logic [N_TRACKS-1:0] loopTab;

  logic [N_TRACKS-1:0] pending;
  logic [3:0]          trackId;
  logic [BEAT_W-1:0]   beatCnt;
  logic [DIV_W-1:0]    divCnt;
  logic                doneR;
  logic                abortR;

  logic [BEAT_W-1:0]   curLen, effLen;
  logic [DIV_W-1:0]    curDiv, effDiv;
  logic [1:0]          curPrio;
  logic                curLoop;
  logic [N_TRACKS-1:0] curMask, grantMask, clrMask;
  logic                tick, lastBeat;
  logic                grantVld, higherPend;
  logic [3:0]          grantIdx;
  logic [1:0]          grantPrio;
  logic                doGrant, doRestart, doFinish, doAbort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TRACKS; i++) begin
        lenTab[i]  <= BEAT_W'(DEF_LEN);
        divTab[i]  <= DIV_W'(DEF_DIV);
        prioTab[i] <= '0;
      end
      loopTab <= '0;
    end else if (cfg_we && ({1'b0, cfg_track} < NUM_TRACKS)) begin
      lenTab[cfg_track]  <= cfg_len;
      divTab[cfg_track]  <= cfg_div;
      prioTab[cfg_track] <= cfg_prio;
      loopTab[cfg_track] <= cfg_loop;
    end
  end

  // The table is read live, so a config write to the playing track applies next cycle.
  assign curLen   = lenTab[trackId];
  assign curDiv   = divTab[trackId];
  assign curPrio  = prioTab[trackId];
  assign curLoop  = loopTab[trackId];
  assign effLen   = (curLen == '0) ? BEAT_W'(1) : curLen;
  assign effDiv   = (curDiv == '0) ? DIV_W'(1) : curDiv;
  assign tick     = (state == PLAY) && (divCnt >= effDiv - DIV_W'(1));
  assign lastBeat = (beatCnt >= effLen - BEAT_W'(1));
  assign curMask  = N_TRACKS'(1) << trackId;
  assign grantMask = N_TRACKS'(1) << grantIdx;

  // Scanning from the top index down lets an equal-priority lower index take over.
  always_comb begin
    grantVld   = 1'b0;
    grantIdx   = '0;
    grantPrio  = '0;
    higherPend = 1'b0;
    for (int i = N_TRACKS - 1; i >= 0; i--) begin
      if (pending[i] && (!grantVld || prioTab[i] >= grantPrio)) begin
        grantVld  = 1'b1;
        grantIdx  = 4'(i);
        grantPrio = prioTab[i];
      end
      if (pending[i] && (prioTab[i] > curPrio)) higherPend = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    doRestart = 1'b0;
    doFinish  = 1'b0;
    doAbort   = 1'b0;
    case (state)
      IDLE: begin
        if (!stop && grantVld) begin
          stateNext = PLAY;
          doGrant   = 1'b1;
        end
      end
      PLAY: begin
        if (stop || higherPend) begin
          stateNext = IDLE;
          doAbort   = 1'b1;
        end else if ((pending & curMask) != '0) begin
          doRestart = 1'b1;
        end else if (tick && lastBeat) begin
          if (curLoop) begin
            doRestart = 1'b1;
          end else begin
            stateNext = IDLE;
            doFinish  = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign clrMask = doGrant ? grantMask : (doRestart ? curMask : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      trackId <= '0;
      beatCnt <= '0;
      divCnt  <= '0;
      doneR   <= 1'b0;
      abortR  <= 1'b0;
    end else begin
      doneR  <= doFinish;
      abortR <= doAbort;
      if (stop) pending <= '0;
      else      pending <= (pending & ~clrMask) | req;
      // trackId survives into the first IDLE cycle so done/aborted can name it.
      if (doGrant)            trackId <= grantIdx;
      else if (state == IDLE) trackId <= '0;
      if (state == IDLE || doRestart || doAbort || doFinish) begin
        beatCnt <= '0;
        divCnt  <= '0;
      end else if (tick) begin
        beatCnt <= beatCnt + BEAT_W'(1);
        divCnt  <= '0;
      end else begin
        divCnt  <= divCnt + DIV_W'(1);
      end
    end
  end

  assign active    = (state == PLAY);
  assign track_id  = trackId;
  assign ibeat     = beatCnt;
  assign beat_tick = tick;
  assign done      = doneR;
  assign aborted   = abortR;

endmodule
